// File: rtl/dmem_bus_bridge.sv
// -----------------------------------------------------------------------------
// dmem_bus_bridge
//
// Turns the single-cycle MIPS data-memory strobes (mem_rd / mem_we, ALU address,
// store data) into one valid/ready request plus response on the memory-mapped
// data bus. While the access is in flight it holds stall high, which freezes
// the PC and the register-file write. In the DONE cycle stall drops for one
// cycle, and rd_dm carries the load data to the write-back mux.
//
// Optional build macro: DMEM_POSTED_WR_EN
//   defined   - writes are posted. A write completes right after its request
//               handshake. Up to MAX_POSTED write responses may be outstanding,
//               and they are retired when they arrive outside WAIT. Reads wait
//               until no writes are pending.
//   undefined - every write waits in WAIT for its response, and there is no
//               pending-write logic.
//
// Ports
//   clk, rst             clock; synchronous active-low reset
//   mem_rd, mem_we       CPU load / store request (level, held while stalled)
//   addr, wdata          CPU byte address and store data
//   rd_dm                load data (ERR_DATA after any error)
//   stall                freeze request to the datapath
//   bus_req_*            request channel (valid/ready, addr, we, wdata)
//   bus_rsp_*            response channel (bridge is always ready)
//   err_bus/timeout/misalign   sticky error flags, cleared only by reset
//
// Parameters
//   ADDR_W          bus address width (<= 32); the CPU address is truncated
//   TIMEOUT_CYCLES  maximum number of cycles in REQ+WAIT before abort (>= 2)
//   ERR_DATA        read data returned on any error
//   MAX_POSTED      limit on outstanding posted writes
// -----------------------------------------------------------------------------
//  state | meaning
//  IDLE  | no access; stall follows the CPU strobes; alignment check
//  REQ   | bus_req_valid high, request held stable until ready
//  WAIT  | request accepted, waiting for the response
//  DONE  | one unstalled cycle; CPU retires the load/store
// -----------------------------------------------------------------------------
module dmem_bus_bridge #(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF,
   parameter int unsigned MAX_POSTED     = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_rd,
   input  logic              mem_we,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rd_dm,
   output logic              stall,
   output logic              bus_req_valid,
   input  logic              bus_req_ready,
   output logic [ADDR_W-1:0] bus_addr,
   output logic              bus_we,
   output logic [31:0]       bus_wdata,
   input  logic              bus_rsp_valid,
   input  logic              bus_rsp_err,
   input  logic [31:0]       bus_rdata,
   output logic              err_bus,
   output logic              err_timeout,
   output logic              err_misalign
);

   if (TIMEOUT_CYCLES < 2 || MAX_POSTED < 1) begin : g_bad_params
      $error("dmem_bus_bridge: TIMEOUT_CYCLES must be >= 2 and MAX_POSTED >= 1");
   end

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [ADDR_W-1:0] addr_lat;
   logic [31:0]       wdata_lat;
   logic              we_lat;

   logic acc_req;
   logic misalign;
   logic req_hs;
   logic tmo;
   logic issue_ok;
   logic posted_wr;

   assign acc_req  = mem_rd | mem_we;
   assign misalign = addr[1:0] != 2'b00;
   assign req_hs   = (state == ST_REQ) && bus_req_ready;

   // A response wins over a timeout in the same cycle, so timeout only fires
   // when the current state's event did not happen.
   assign tmo = (cnt == CNT_LAST) &&
                (((state == ST_REQ)  && !bus_req_ready) ||
                 ((state == ST_WAIT) && !bus_rsp_valid));

`ifdef DMEM_POSTED_WR_EN
   localparam int unsigned       PEND_W   = $clog2(MAX_POSTED + 1);
   localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_POSTED);

   logic [PEND_W-1:0] pending;
   logic              pend_inc;
   logic              pend_dec;

   // Reads must not overtake posted writes; writes only need a free slot.
   assign issue_ok  = mem_we ? (pending < PEND_MAX) : (pending == '0);
   assign posted_wr = we_lat;
   assign pend_inc  = req_hs && we_lat;
   // Outside WAIT a response can only belong to a posted write.
   assign pend_dec  = bus_rsp_valid && (state != ST_WAIT) && (pending != '0);

   always_ff @(posedge clk) begin
      if (!rst) begin
         pending <= '0;
      end else begin
         case ({pend_inc, pend_dec})
            2'b10:   pending <= pending + 1'b1;
            2'b01:   pending <= pending - 1'b1;
            default: pending <= pending;
         endcase
      end
   end
`else
   assign issue_ok  = 1'b1;
   assign posted_wr = 1'b0;
`endif

   // state register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (acc_req) begin
               if (misalign) begin
                  state_nxt = ST_DONE;
               end else if (issue_ok) begin
                  state_nxt = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            if (req_hs) begin
               state_nxt = posted_wr ? ST_DONE : ST_WAIT;
            end else if (tmo) begin
               state_nxt = ST_DONE;
            end
         end
         ST_WAIT: begin
            if (bus_rsp_valid || tmo) begin
               state_nxt = ST_DONE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // output logic
   always_comb begin
      stall         = 1'b0;
      bus_req_valid = 1'b0;
      case (state)
         // Reset holds stall low even if the CPU strobes are still up.
         ST_IDLE: stall = acc_req & rst;
         ST_REQ: begin
            stall         = 1'b1;
            bus_req_valid = 1'b1;
         end
         ST_WAIT: stall = 1'b1;
         default: stall = 1'b0;
      endcase
   end

   assign bus_addr  = addr_lat;
   assign bus_we    = we_lat;
   assign bus_wdata = wdata_lat;

   // Access latch, timeout counter, load data and sticky flags.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt          <= '0;
         addr_lat     <= '0;
         wdata_lat    <= '0;
         we_lat       <= 1'b0;
         rd_dm        <= '0;
         err_bus      <= 1'b0;
         err_timeout  <= 1'b0;
         err_misalign <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (acc_req) begin
                  if (misalign) begin
                     err_misalign <= 1'b1;
                     rd_dm        <= ERR_DATA;
                  end else if (issue_ok) begin
                     addr_lat  <= addr[ADDR_W-1:0];
                     wdata_lat <= wdata;
                     we_lat    <= mem_we;
                     cnt       <= '0;
                  end
               end
            end
            // Saturate so that a handshake on the last REQ cycle cannot
            // restart the budget for WAIT.
            ST_REQ, ST_WAIT: begin
               if (cnt != CNT_LAST) begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase

         if ((state == ST_WAIT) && bus_rsp_valid) begin
            if (bus_rsp_err) begin
               rd_dm   <= ERR_DATA;
               err_bus <= 1'b1;
            end else if (!we_lat) begin
               rd_dm <= bus_rdata;
            end
         end

         if (tmo) begin
            rd_dm       <= ERR_DATA;
            err_timeout <= 1'b1;
         end

`ifdef DMEM_POSTED_WR_EN
         if (pend_dec && bus_rsp_err) begin
            err_bus <= 1'b1;
         end
`endif
      end
   end

endmodule

// File: tb/tb_dmem_bus_bridge.sv
module tb_dmem_bus_bridge;

   localparam int NEVER = 9999;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_rd, mem_we;
   logic [31:0] addr, wdata;
   logic [31:0] rd_dm;
   logic        stall;
   logic        bus_req_valid, bus_req_ready;
   logic [31:0] bus_addr;
   logic        bus_we;
   logic [31:0] bus_wdata;
   logic        bus_rsp_valid, bus_rsp_err;
   logic [31:0] bus_rdata;
   logic        err_bus, err_timeout, err_misalign;

   int n_assert = 0;
   int n_fail   = 0;

   dmem_bus_bridge dut (
      .clk           (clk),
      .rst           (rst),
      .mem_rd        (mem_rd),
      .mem_we        (mem_we),
      .addr          (addr),
      .wdata         (wdata),
      .rd_dm         (rd_dm),
      .stall         (stall),
      .bus_req_valid (bus_req_valid),
      .bus_req_ready (bus_req_ready),
      .bus_addr      (bus_addr),
      .bus_we        (bus_we),
      .bus_wdata     (bus_wdata),
      .bus_rsp_valid (bus_rsp_valid),
      .bus_rsp_err   (bus_rsp_err),
      .bus_rdata     (bus_rdata),
      .err_bus       (err_bus),
      .err_timeout   (err_timeout),
      .err_misalign  (err_misalign)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Runs one CPU access against a simple slave. Entered and left at posedge+1
   // with the bridge in IDLE. The slave raises ready after rdy_dly valid cycles,
   // and it responds rsp_dly cycles after the handshake. pre_rsp stray response
   // pulses are driven in the first cycles of the access.
   task automatic do_access(input string tag, input logic rd, input logic we,
                            input logic [31:0] a, input logic [31:0] wd,
                            input int rdy_dly, input int rsp_dly,
                            input logic [31:0] rdat, input logic rerr,
                            input int pre_rsp, input logic pre_err,
                            output int n_stall, output int n_valid,
                            output logic stable, output logic [31:0] rd_done);
      int since_hs;
      logic done;
      n_stall = 0; n_valid = 0; stable = 1'b1; rd_done = '0;
      since_hs = -1; done = 1'b0;
      mem_rd = rd; mem_we = we; addr = a; wdata = wd;
      for (int c = 0; c < 300 && !done; c++) begin
         if (since_hs >= 0) since_hs++;
         bus_rsp_valid = (c < pre_rsp) || (since_hs == rsp_dly);
         bus_rsp_err   = (c < pre_rsp) ? pre_err : rerr;
         bus_rdata     = (c < pre_rsp) ? 32'h5555_5555 : rdat;
         bus_req_ready = bus_req_valid && (n_valid >= rdy_dly);
         #4;
         if (stall) n_stall++;
         else begin
            done    = 1'b1;
            rd_done = rd_dm;
         end
         if (bus_req_valid) begin
            if (bus_addr !== a || bus_we !== we || bus_wdata !== wd) stable = 1'b0;
            if (bus_req_ready) since_hs = 0;
            n_valid++;
         end
         if (done) begin
            mem_rd = 1'b0;
            mem_we = 1'b0;
         end
         @(posedge clk); #1;
         bus_rsp_valid = 1'b0;
         bus_req_ready = 1'b0;
      end
      check({tag, "_completed"}, {31'd0, done}, 32'd1);
   endtask

   initial begin
      int ns, nv;
      logic st;
      logic [31:0] rdv;

      rst = 1'b0; mem_rd = 0; mem_we = 0; addr = '0; wdata = '0;
      bus_req_ready = 0; bus_rsp_valid = 0; bus_rsp_err = 0; bus_rdata = '0;

      repeat (3) @(posedge clk);
      #5;
      check("rst_rd_dm", rd_dm, 32'd0);
      check("rst_stall", {31'd0, stall}, 32'd0);
      check("rst_valid", {31'd0, bus_req_valid}, 32'd0);
      check("rst_flags", {29'd0, err_bus, err_timeout, err_misalign}, 32'd0);
      check("rst_bus_addr", bus_addr, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      // aligned load, ready at once, response one cycle later
      do_access("ld100", 1, 0, 32'h100, 32'h0, 0, 1, 32'h1234_5678, 0, 0, 0, ns, nv, st, rdv);
      check("ld100_stall", ns, 3);
      check("ld100_valid", nv, 1);
      check("ld100_bus_stable", {31'd0, st}, 32'd1);
      check("ld100_rd_dm", rdv, 32'h1234_5678);
      check("ld100_flags", {29'd0, err_bus, err_timeout, err_misalign}, 32'd0);

`ifndef DMEM_POSTED_WR_EN
      // store with ready withheld for 5 valid cycles
      do_access("st204", 0, 1, 32'h204, 32'hCAFE_F00D, 5, 1, 32'h0, 0, 0, 0, ns, nv, st, rdv);
      check("st204_stall", ns, 8);
      check("st204_valid", nv, 6);
      check("st204_bus_stable", {31'd0, st}, 32'd1);
      check("st204_rd_dm_held", rdv, 32'h1234_5678);
      check("st204_flags", {29'd0, err_bus, err_timeout, err_misalign}, 32'd0);

      // rd and we together is a write
      do_access("rdwe208", 1, 1, 32'h208, 32'h0F0F_0F0F, 0, 1, 32'h7777_7777, 0, 0, 0, ns, nv, st, rdv);
      check("rdwe208_stall", ns, 3);
      check("rdwe208_is_write", {31'd0, st}, 32'd1);
      check("rdwe208_rd_dm_held", rdv, 32'h1234_5678);
`endif

      // misaligned load with a stray erroring response in IDLE
      do_access("ld102", 1, 0, 32'h102, 32'h0, 0, 1, 32'h0, 0, 1, 1, ns, nv, st, rdv);
      check("ld102_stall", ns, 1);
      check("ld102_valid", nv, 0);
      check("ld102_rd_dm", rdv, 32'hDEAD_BEEF);
      check("ld102_misalign", {31'd0, err_misalign}, 32'd1);
      check("ld102_stray_err_ignored", {31'd0, err_bus}, 32'd0);

      do_access("ld108", 1, 0, 32'h108, 32'h0, 2, 3, 32'hA5A5_5A5A, 0, 0, 0, ns, nv, st, rdv);
      check("ld108_stall", ns, 7);
      check("ld108_valid", nv, 3);
      check("ld108_rd_dm", rdv, 32'hA5A5_5A5A);

      // response on the final budget cycle beats the timeout
      do_access("ld10c", 1, 0, 32'h10C, 32'h0, 0, 63, 32'h600D_CAFE, 0, 0, 0, ns, nv, st, rdv);
      check("ld10c_stall", ns, 65);
      check("ld10c_rd_dm", rdv, 32'h600D_CAFE);
      check("ld10c_no_timeout", {31'd0, err_timeout}, 32'd0);

      // no ready ever: abort after 64 REQ cycles
      do_access("ld110", 1, 0, 32'h110, 32'h0, NEVER, NEVER, 32'h0, 0, 0, 0, ns, nv, st, rdv);
      check("ld110_valid", nv, 64);
      check("ld110_stall", ns, 65);
      check("ld110_rd_dm", rdv, 32'hDEAD_BEEF);
      check("ld110_timeout", {31'd0, err_timeout}, 32'd1);

      // late response in IDLE must be ignored
      do_access("ld114", 1, 0, 32'h114, 32'h0, 0, 1, 32'h1357_9BDF, 0, 1, 1, ns, nv, st, rdv);
      check("ld114_stall", ns, 3);
      check("ld114_rd_dm", rdv, 32'h1357_9BDF);
      check("ld114_late_rsp_ignored", {31'd0, err_bus}, 32'd0);

      do_access("ld118", 1, 0, 32'h118, 32'h0, 0, 1, 32'h2468_ACE0, 1, 0, 0, ns, nv, st, rdv);
      check("ld118_rd_dm", rdv, 32'hDEAD_BEEF);
      check("ld118_err_bus", {31'd0, err_bus}, 32'd1);

      // reset while in WAIT
      mem_rd = 1; addr = 32'h120; wdata = '0; bus_req_ready = 1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus_req_ready = 0;
      rst = 1'b0;
      #4;
      check("wait_stall_before_rst", {31'd0, stall}, 32'd1);
      @(posedge clk); #5;
      check("rst_wait_stall", {31'd0, stall}, 32'd0);
      check("rst_wait_valid", {31'd0, bus_req_valid}, 32'd0);
      check("rst_wait_flags", {29'd0, err_bus, err_timeout, err_misalign}, 32'd0);
      check("rst_wait_rd_dm", rd_dm, 32'd0);
      @(posedge clk); #1;
      mem_rd = 0; rst = 1'b1;
      @(posedge clk); #1;

`ifdef DMEM_POSTED_WR_EN
      for (int i = 0; i < 4; i++) begin
         do_access("pst", 0, 1, 32'h400 + 32'(4 * i), 32'h1000_0000 + 32'(i), 0, NEVER,
                   32'h0, 0, 0, 0, ns, nv, st, rdv);
         check("pst_stall", ns, 2);
         check("pst_stable", {31'd0, st}, 32'd1);
      end
      // fifth store blocks until one response frees a slot
      do_access("pst5", 0, 1, 32'h410, 32'h1000_0004, 0, NEVER, 32'h0, 0, 1, 0, ns, nv, st, rdv);
      check("pst5_stall", ns, 3);
      // load waits for all four outstanding responses
      do_access("pld500", 1, 0, 32'h500, 32'h0, 0, 1, 32'hFEED_FACE, 0, 4, 0, ns, nv, st, rdv);
      check("pld500_stall", ns, 7);
      check("pld500_rd_dm", rdv, 32'hFEED_FACE);
      check("pld500_err_bus", {31'd0, err_bus}, 32'd0);
      do_access("pst504", 0, 1, 32'h504, 32'h0, 0, NEVER, 32'h0, 0, 0, 0, ns, nv, st, rdv);
      check("pst504_stall", ns, 2);
      do_access("pld508", 1, 0, 32'h508, 32'h0, 0, 1, 32'h0102_0304, 0, 1, 1, ns, nv, st, rdv);
      check("pld508_stall", ns, 4);
      check("pld508_rd_dm", rdv, 32'h0102_0304);
      check("pld508_wr_err", {31'd0, err_bus}, 32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
